// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric
// Memory-mapped interconnect between the CPU data port and NUM_SLAVES
// peripherals. Each request is decoded against per-slave base/mask regions,
// forwarded to exactly one slave, and completed with a single-cycle response
// pulse. Decode misses and unanswered requests complete with an error.
// Only one transaction is outstanding at a time.

module mmio_bus_fabric #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m_req,
  input  logic                             m_we,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic [DATA_WIDTH/8-1:0]          m_be,
  output logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_err,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic                             s_we,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_be,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  output logic [7:0]                       err_count
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
  logic                  s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [BE_W-1:0]       s_be_q, s_be_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic [ADDR_WIDTH-1:0] hit_offset;

  logic                  ack_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic [NUM_SLAVES-1:0] sel_onehot;

  // Address decode: scanning from the highest slave down lets the lowest
  // matching index overwrite the others, so it wins on overlapping regions.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_offset = m_addr;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((m_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit        = 1'b1;
        hit_idx    = IDX_W'(k);
        hit_offset = m_addr & ~SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Pick out the ack and read data of the latched slave; other slaves' acks are ignored.
  always_comb begin
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_idx_q == IDX_W'(k)) begin
        ack_sel   = s_ack[k];
        rdata_sel = s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
      sel_onehot[k] = (state_q == ST_WAIT) && (sel_idx_q == IDX_W'(k));
    end
  end

  // Next-state logic: latch in IDLE, wait for ack or timeout, pulse response once.
  always_comb begin
    state_d     = state_q;
    sel_idx_d   = sel_idx_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_be_d      = s_be_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (m_req) begin
          sel_idx_d = hit_idx;
          s_we_d    = m_we;
          s_addr_d  = hit_offset;
          s_wdata_d = m_wdata;
          s_be_d    = m_be;
          cnt_d     = '0;
          if (hit) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (ack_sel) begin
          rdata_d = s_we_q ? '0 : rdata_sel;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
        if (err_q && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_idx_q   <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_be_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_idx_q   <= sel_idx_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_be_q      <= s_be_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // Response outputs are forced to zero outside the single RESP cycle.
  always_comb begin
    m_ready   = (state_q == ST_RESP);
    m_rdata   = m_ready ? rdata_q : '0;
    m_err     = m_ready & err_q;
    s_sel     = sel_onehot;
    s_we      = s_we_q;
    s_addr    = s_addr_q;
    s_wdata   = s_wdata_q;
    s_be      = s_be_q;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// tb_mmio_bus_fabric
// Randomized and directed bench for mmio_bus_fabric in a two-slave setup
// (timer at 0x0200_xxxx, dmem at 0x100x_xxxx, timeout of 8 cycles).
// Expected behaviour comes from a transaction-level reference model.

module tb_mmio_bus_fabric;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam int NEVER = 1000;

  logic            clk;
  logic            rst;
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic [N-1:0]    s_sel;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_be;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ack;
  logic [7:0]      err_count;

  int checkCount = 0;
  int errorCount = 0;
  int errRef     = 0;

  logic [31:0] refBase [N];
  logic [31:0] refMask [N];

  mmio_bus_fabric #(
    .NUM_SLAVES     (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T),
    .SLAVE_BASE     ({32'h1000_0000, 32'h0200_0000}),
    .SLAVE_MASK     ({32'hFFF0_0000, 32'hFFFF_0000})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_be      (s_be),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .err_count (err_count)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference decode: first region (lowest index) whose masked bits match
  task automatic decodeRef(input logic [31:0] addr, output bit hit, output int idx, output logic [31:0] offset);
    hit = 0;
    idx = 0;
    offset = addr;
    for (int k = 0; k < N; k++) begin
      if (!hit && ((addr & refMask[k]) == (refBase[k] & refMask[k]))) begin
        hit = 1;
        idx = k;
        offset = addr - (addr & refMask[k]);
      end
    end
  endtask

  // Run one transaction starting in the current (idle) cycle. ackDelay counts
  // cycles after the select first appears; values >= T mean the slave stays silent.
  task automatic applyStimulus(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                               input logic [3:0] be, input int ackDelay, input logic [31:0] ackData,
                               input bit stray, input bit dropReq);
    bit          hit;
    int          idx;
    logic [31:0] offset;
    int          readyCycle;
    bit          expErr;
    logic [31:0] expRdata;
    logic [31:0] expSel;

    decodeRef(addr, hit, idx, offset);
    if (!hit) begin
      readyCycle = 1;
      expErr     = 1;
      expRdata   = 0;
    end else if (ackDelay < T) begin
      readyCycle = 2 + ackDelay;
      expErr     = 0;
      expRdata   = we ? 32'h0 : ackData;
    end else begin
      readyCycle = 1 + T;
      expErr     = 1;
      expRdata   = 0;
    end

    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_be    = be;
    s_ack   = '0;

    for (int c = 1; c <= readyCycle; c++) begin
      @(posedge clk);
      #1;
      expSel = (hit && c < readyCycle) ? (32'h1 << idx) : 32'h0;
      checkOutput("s_sel", {30'b0, s_sel}, expSel);
      checkOutput("m_ready", {31'b0, m_ready}, {31'b0, c == readyCycle});
      checkOutput("m_rdata", m_rdata, (c == readyCycle) ? expRdata : 32'h0);
      checkOutput("m_err", {31'b0, m_err}, (c == readyCycle) ? {31'b0, expErr} : 32'h0);
      if (c == 1 && hit) begin
        checkOutput("s_addr", s_addr, offset);
        checkOutput("s_we", {31'b0, s_we}, {31'b0, we});
        checkOutput("s_wdata", s_wdata, wdata);
        checkOutput("s_be", {28'b0, s_be}, {28'b0, be});
      end

      if (dropReq) begin
        m_req   = 1'b0;
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_be    = 4'($urandom);
        m_we    = 1'($urandom);
      end
      if (c == readyCycle) m_req = 1'b0;
      s_ack   = '0;
      s_rdata = {$urandom, $urandom};
      if (hit && c < readyCycle) begin
        if (c == 1 + ackDelay) begin
          s_ack[idx] = 1'b1;
          s_rdata[idx*32 +: 32] = ackData;
        end
        if (stray && ($urandom_range(0, 1) == 1)) s_ack[1-idx] = 1'b1;
      end
    end

    m_req = 1'b0;
    s_ack = '0;
    if (expErr && errRef < 255) errRef++;
    @(posedge clk);
    #1;
    checkOutput("err_count", {24'b0, err_count}, errRef);
    checkOutput("idle_ready", {31'b0, m_ready}, 32'h0);
  endtask

  initial begin
    int          r;
    logic [31:0] addr;

    refBase[0] = 32'h0200_0000; refMask[0] = 32'hFFFF_0000;
    refBase[1] = 32'h1000_0000; refMask[1] = 32'hFFF0_0000;

    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_rdata = '0; s_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_ready", {31'b0, m_ready}, 32'h0);
    checkOutput("rst_m_rdata", m_rdata, 32'h0);
    checkOutput("rst_m_err", {31'b0, m_err}, 32'h0);
    checkOutput("rst_s_sel", {30'b0, s_sel}, 32'h0);
    checkOutput("rst_s_we", {31'b0, s_we}, 32'h0);
    checkOutput("rst_s_addr", s_addr, 32'h0);
    checkOutput("rst_s_wdata", s_wdata, 32'h0);
    checkOutput("rst_s_be", {28'b0, s_be}, 32'h0);
    checkOutput("rst_err_count", {24'b0, err_count}, 32'h0);
    rst = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus(32'h1000_0040, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    applyStimulus(32'h0200_0004, 1'b1, 32'h0000_1234, 4'b0011, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    applyStimulus(32'h1000_0000, 1'b0, 32'h0, 4'hF, NEVER, 32'h0, 1'b0, 1'b0);
    applyStimulus(32'h1000_0100, 1'b0, 32'h0, 4'hF, T - 1, 32'h5A5A_A5A5, 1'b1, 1'b0);
    applyStimulus(32'h100F_FFFC, 1'b0, 32'h0, 4'hF, 3, 32'h1357_9BDF, 1'b1, 1'b1);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0)      addr = 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
      else if (r == 1) addr = 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
      else             addr = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFF);
      applyStimulus(addr, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, T + 1),
                    $urandom, 1'($urandom), 1'($urandom));
    end

    $display("[TB] reset during WAIT");
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0010; m_wdata = '0; m_be = 4'hF; s_ack = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      m_req = 1'b0;
    end
    checkOutput("pre_rst_s_sel", {30'b0, s_sel}, 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    errRef = 0;
    checkOutput("mid_rst_s_sel", {30'b0, s_sel}, 32'h0);
    checkOutput("mid_rst_m_ready", {31'b0, m_ready}, 32'h0);
    checkOutput("mid_rst_err_count", {24'b0, err_count}, 32'h0);
    rst = 1'b0;
    repeat (T + 2) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_m_ready", {31'b0, m_ready}, 32'h0);
      checkOutput("post_rst_s_sel", {30'b0, s_sel}, 32'h0);
    end

    $display("[TB] error counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(32'h3000_0000 | ($urandom & 32'h0FFF_FFFF), 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    end
    checkOutput("err_count_sat", {24'b0, err_count}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
